// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Merges two writeback sources onto the single register-file write port.
//   ALU results arrive with a valid/ready handshake. Load results arrive from
//   the memory stage without per-beat back-pressure, so they are buffered in
//   a 2-entry FIFO. mem_stall tells the producer to hold while that FIFO is
//   full. One grant is issued per cycle, and the winner is written through a
//   registered write port one cycle later. Decode can query whether a write
//   to a source register is still in flight (chk_hit1/chk_hit2).
//
// Configuration:
//   WB_ARB_ROUND_ROBIN_EN - when defined, a contention cycle is won by the
//   requester that did not win the previous grant. A last_grant register
//   tracks this and starts at ALU, so MEM wins the first contention after
//   reset. When undefined, MEM always beats ALU and last_grant is absent.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   alu_valid  in   1  ALU writeback request
//   alu_ready  out  1  ALU request accepted this cycle (combinational)
//   alu_addr   in   5  ALU destination register
//   alu_data   in  32  ALU result
//   mem_valid  in   1  load writeback beat (never back-pressured)
//   mem_addr   in   5  load destination register
//   mem_data   in  32  load value
//   mem_stall  out  1  MEM FIFO full, producer must hold (combinational)
//   rf_we      out  1  register-file write enable (registered)
//   rf_waddr   out  5  register-file write address (registered)
//   rf_wdata   out 32  register-file write data (registered)
//   chk_addr1  in   5  decode source address 1
//   chk_addr2  in   5  decode source address 2
//   chk_hit1   out  1  write to chk_addr1 pending (combinational)
//   chk_hit2   out  1  write to chk_addr2 pending (combinational)
//   ovf_err    out  1  sticky: MEM beat arrived while FIFO was full
// -----------------------------------------------------------------------------
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        chk_hit1,
    output logic        chk_hit2,
    output logic        ovf_err
);

    // FIFO entry layout: {addr[4:0], data[31:0]}
    localparam int ENTRY_W = 37;

`ifdef WB_ARB_ROUND_ROBIN_EN
    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;
`endif

    // Pending-write lookup: a non-zero address hits any valid FIFO entry or
    // the write currently being presented on the output port.
    function automatic logic addr_pending(
        input logic [4:0] addr,
        input logic       v0,
        input logic [4:0] a0,
        input logic       v1,
        input logic [4:0] a1,
        input logic       we,
        input logic [4:0] wa
    );
        logic hit;
        hit = 1'b0;
        if (addr != 5'd0) begin
            hit = (v0 && (a0 == addr)) || (v1 && (a1 == addr)) || (we && (wa == addr));
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_q [2];
    logic [ENTRY_W-1:0] fifo_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               rf_we_q, rf_we_d;
    logic [4:0]         rf_waddr_q, rf_waddr_d;
    logic [31:0]        rf_wdata_q, rf_wdata_d;
    logic               ovf_err_q, ovf_err_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
    grant_e             last_grant_q, last_grant_d;
`endif

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic               push_req_s;
    logic               full_s;
    logic               push_s;
    logic               mem_cand_s;
    logic               alu_cand_s;
    logic               mem_grant_s;
    logic               alu_grant_s;
    logic [ENTRY_W-1:0] head_s;
    logic               ent0_valid_s;
    logic               ent1_valid_s;

    // Request qualification and FIFO status
    always_comb begin
        push_req_s = mem_valid && (mem_addr != 5'd0);
        full_s     = (count_q == 2'd2);
        // A beat that finds the FIFO full is dropped even if a pop happens
        // in the same cycle; the producer was already told to stall.
        push_s     = push_req_s && !full_s;
        mem_cand_s = (count_q != 2'd0);
        alu_cand_s = alu_valid && (alu_addr != 5'd0);
        head_s     = fifo_q[rd_ptr_q];
    end

    // Which physical slots hold live entries, derived from count and rd_ptr
    always_comb begin
        ent0_valid_s = 1'b0;
        ent1_valid_s = 1'b0;
        case (count_q)
            2'd2: begin
                ent0_valid_s = 1'b1;
                ent1_valid_s = 1'b1;
            end
            2'd1: begin
                ent0_valid_s = (rd_ptr_q == 1'b0);
                ent1_valid_s = (rd_ptr_q == 1'b1);
            end
            default: begin
                ent0_valid_s = 1'b0;
                ent1_valid_s = 1'b0;
            end
        endcase
    end

    // Single-winner arbitration between FIFO head and ALU
    always_comb begin
        mem_grant_s = 1'b0;
        alu_grant_s = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
        if (mem_cand_s && alu_cand_s) begin
            // Contention: the requester that did not win last time goes now
            mem_grant_s = (last_grant_q == GNT_ALU);
            alu_grant_s = (last_grant_q == GNT_MEM);
        end else begin
            mem_grant_s = mem_cand_s;
            alu_grant_s = alu_cand_s;
        end
`else
        if (mem_cand_s) begin
            mem_grant_s = 1'b1;
            alu_grant_s = 1'b0;
        end else begin
            mem_grant_s = 1'b0;
            alu_grant_s = alu_cand_s;
        end
`endif
    end

    // Next-state: FIFO storage, pointers and occupancy
    always_comb begin
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = {mem_addr, mem_data};
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (mem_grant_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, mem_grant_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Next-state: write port register, overflow flag, grant history
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (mem_grant_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_s[36:32];
            rf_wdata_d = head_s[31:0];
        end else if (alu_grant_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = alu_addr;
            rf_wdata_d = alu_data;
        end else begin
            // No grant: address/data hold so the port is quiet
            rf_we_d = 1'b0;
        end
        if (push_req_s && full_s) begin
            ovf_err_d = 1'b1;
        end else begin
            ovf_err_d = ovf_err_q;
        end
`ifdef WB_ARB_ROUND_ROBIN_EN
        if (mem_grant_s) begin
            last_grant_d = GNT_MEM;
        end else if (alu_grant_s) begin
            last_grant_d = GNT_ALU;
        end else begin
            last_grant_d = last_grant_q;
        end
`endif
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_q[0]    <= {ENTRY_W{1'b0}};
            fifo_q[1]    <= {ENTRY_W{1'b0}};
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= 32'd0;
            ovf_err_q    <= 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_grant_q <= GNT_ALU;
`endif
        end else begin
            fifo_q[0]    <= fifo_d[0];
            fifo_q[1]    <= fifo_d[1];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            ovf_err_q    <= ovf_err_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Combinational outputs; all forced low while reset is asserted because
    // the synchronous reset has not yet cleared the state they depend on.
    always_comb begin
        if (rst_n) begin
            // A zero-address ALU request is accepted and dropped immediately
            alu_ready = alu_grant_s || (alu_valid && (alu_addr == 5'd0));
            mem_stall = full_s;
            chk_hit1  = addr_pending(chk_addr1, ent0_valid_s, fifo_q[0][36:32],
                                     ent1_valid_s, fifo_q[1][36:32], rf_we_q, rf_waddr_q);
            chk_hit2  = addr_pending(chk_addr2, ent0_valid_s, fifo_q[0][36:32],
                                     ent1_valid_s, fifo_q[1][36:32], rf_we_q, rf_waddr_q);
        end else begin
            alu_ready = 1'b0;
            mem_stall = 1'b0;
            chk_hit1  = 1'b0;
            chk_hit2  = 1'b0;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign ovf_err  = ovf_err_q;

endmodule
